// File: rtl/dff_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dff_ctrl_pkg
// Shared definitions for the shared enable-flop access arbiter:
//   state_t       : arbiter FSM state encoding (IDLE, ISSUE, CHECK)
//   OP_WRITE      : req_op value for a data write into the flop
//   OP_CLEAR      : req_op value for a synchronous clear of the flop
//   DEF_N_REQ     : default number of requesters
// -----------------------------------------------------------------------------
package dff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_CLEAR  = 1'b1;

    localparam int   DEF_N_REQ = 4;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at index ptr and wraps
// modulo N_REQ; the first asserted request wins.
// Ports:
//   req       in  N_REQ  request vector
//   ptr       in  PTR_W  index with highest priority
//   grant     out N_REQ  one-hot winner, zero when req is zero
//   grant_idx out PTR_W  binary index of the winner (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(N_REQ)) begin
                sum = sum - SUM_W'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_access_arbiter.sv
// -----------------------------------------------------------------------------
// dff_access_arbiter
// Arbitrates N_REQ requesters onto one shared enable-flop. Each granted
// access is one ISSUE cycle (drive write or clear) followed by one CHECK
// cycle (read the flop back, pulse ack, compare against the expected value).
//
// Handshake: req is a level request. The arbiter answers with a registered
// one-hot gnt that stays stable from ISSUE through CHECK; req_op/req_d are
// sampled only during ISSUE. Completion is a single-cycle ack on the granted
// bit during CHECK, with rdata valid in that same cycle. Dropping req after
// the grant does not cancel the access.
//
// Ports:
//   clk        in   1      clock, all state on posedge
//   reset_n    in   1      asynchronous active-low reset
//   req        in   N_REQ  per-requester access request
//   req_op     in   N_REQ  per-requester op (OP_WRITE / OP_CLEAR)
//   req_d      in   N_REQ  per-requester write data
//   gnt        out  N_REQ  one-hot grant, zero when idle
//   ack        out  N_REQ  completion pulse to the granted requester
//   rdata      out  1      flop value read back, valid with ack
//   dff_en     out  1      shared flop enable
//   dff_d      out  1      shared flop data
//   dff_reset  out  1      shared flop synchronous clear
//   dff_q      in   1      shared flop output
//   err        out  1      sticky read-back mismatch flag
//   err_cnt    out  ERR_W  saturating mismatch count
//   fsm_state  out  2      current FSM state, for observation
// -----------------------------------------------------------------------------
module dff_access_arbiter
    import dff_ctrl_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_op,
    input  logic [N_REQ-1:0] req_d,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic             rdata,
    output logic             dff_en,
    output logic             dff_d,
    output logic             dff_reset,
    input  logic             dff_q,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output state_t           fsm_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             exp_q, exp_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] ptr_next;
    logic             sel_op;
    logic             sel_d;

    // In CHECK the requester just served is excluded, so a lone requester
    // that keeps req high goes back through IDLE before being re-granted.
    assign arb_req = (state_q == CHECK) ? (req & ~gnt_q) : req;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (ptr_q),
        .grant     (pick),
        .grant_idx (pick_idx)
    );

    // Priority after a grant starts one past the winner.
    assign ptr_next = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : (pick_idx + 1'b1);

    assign sel_op = |(req_op & gnt_q);
    assign sel_d  = |(req_d & gnt_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            exp_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        exp_d     = exp_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        dff_en    = 1'b0;
        dff_d     = 1'b0;
        dff_reset = 1'b0;
        ack       = '0;
        rdata     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    ptr_d   = ptr_next;
                    state_d = ISSUE;
                end else begin
                    gnt_d = '0;
                end
            end

            ISSUE: begin
                case (sel_op)
                    OP_WRITE: begin
                        dff_en = 1'b1;
                        dff_d  = sel_d;
                        exp_d  = sel_d;
                    end
                    OP_CLEAR: begin
                        dff_reset = 1'b1;
                        exp_d     = 1'b0;
                    end
                    default: ;
                endcase
                state_d = CHECK;
            end

            CHECK: begin
                ack   = gnt_q;
                rdata = dff_q;
                if (dff_q != exp_q) begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
                if (|arb_req) begin
                    gnt_d   = pick;
                    ptr_d   = ptr_next;
                    state_d = ISSUE;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_dff_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_access_arbiter
// Directed bench for dff_access_arbiter with a behavioural model of the
// shared enable-flop (optionally stuck at zero to provoke mismatches).
// -----------------------------------------------------------------------------
module tb_dff_access_arbiter;
    import dff_ctrl_pkg::*;

    localparam int N = 4;
    localparam int EW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_op = '0;
    logic [N-1:0]  req_d = '0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          rdata;
    logic          dff_en;
    logic          dff_d;
    logic          dff_reset;
    logic          dff_q;
    logic          err;
    logic [EW-1:0] err_cnt;
    state_t        fsm_state;

    int n_vec = 0;
    int n_bad = 0;

    dff_access_arbiter #(.N_REQ(N), .ERR_W(EW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_op    (req_op),
        .req_d     (req_d),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .dff_en    (dff_en),
        .dff_d     (dff_d),
        .dff_reset (dff_reset),
        .dff_q     (dff_q),
        .err       (err),
        .err_cnt   (err_cnt),
        .fsm_state (fsm_state)
    );

    // ---------------- shared flop model ----------------
    logic stuck0 = 1'b0;
    logic flop_q = 1'b0;
    always @(posedge clk) begin
        if (dff_reset)   flop_q <= 1'b0;
        else if (dff_en) flop_q <= stuck0 ? 1'b0 : dff_d;
    end
    assign dff_q = flop_q;

    // ---------------- continuous protocol checks ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            n_vec++;
            if (dff_en && dff_reset) begin
                n_bad++;
                $display("FAIL excl: dff_en=%b dff_reset=%b, required not both 1", dff_en, dff_reset);
            end
            if ((ack & ~gnt) != '0) begin
                n_bad++;
                $display("FAIL ack_in_gnt: ack=%b gnt=%b, required ack subset of gnt", ack, gnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req = '0; req_op = '0; req_d = '0;
        step();
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        step();
        n_vec++;
        if ({gnt, ack, rdata, dff_en, dff_d, dff_reset, err} !== '0 || err_cnt !== '0 || fsm_state !== IDLE) begin
            n_bad++;
            $display("FAIL reset: gnt=%b ack=%b rdata=%b en=%b d=%b rst=%b err=%b cnt=%0d st=%0d, required all 0",
                     gnt, ack, rdata, dff_en, dff_d, dff_reset, err, err_cnt, fsm_state);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        req = 4'b0010; req_op = 4'b0000; req_d = 4'b0010;
        n_vec++;
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL wr_c0_gnt: got %b required 0000", gnt); end
        step();
        n_vec++;
        if (gnt !== 4'b0010 || dff_en !== 1'b1 || dff_d !== 1'b1 || dff_reset !== 1'b0 || ack !== 4'b0000) begin
            n_bad++;
            $display("FAIL wr_c1: gnt=%b en=%b d=%b rst=%b ack=%b, required 0010 1 1 0 0000", gnt, dff_en, dff_d, dff_reset, ack);
        end
        req = '0;
        step();
        n_vec++;
        if (ack !== 4'b0010 || rdata !== 1'b1 || dff_en !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_c2: ack=%b rdata=%b en=%b, required 0010 1 0", ack, rdata, dff_en);
        end
        step();
        n_vec++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || err !== 1'b0 || fsm_state !== IDLE) begin
            n_bad++;
            $display("FAIL wr_c3: gnt=%b ack=%b err=%b st=%0d, required 0000 0000 0 IDLE", gnt, ack, err, fsm_state);
        end
    endtask

    task automatic test_clear();
        req = 4'b0100; req_op = 4'b0100; req_d = 4'b0000;
        step();
        n_vec++;
        if (gnt !== 4'b0100 || dff_reset !== 1'b1 || dff_en !== 1'b0 || dff_d !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_c1: gnt=%b rst=%b en=%b d=%b, required 0100 1 0 0", gnt, dff_reset, dff_en, dff_d);
        end
        req = '0; req_op = '0;
        step();
        n_vec++;
        if (ack !== 4'b0100 || rdata !== 1'b0 || dff_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_c2: ack=%b rdata=%b rst=%b, required 0100 0 0", ack, rdata, dff_reset);
        end
        step();
        n_vec++;
        if (err !== 1'b0 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_err: err=%b cnt=%0d, required 0 0", err, err_cnt);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g;
        logic [N-1:0] dpat;
        apply_reset();
        dpat = 4'b0101;
        req = 4'b1111; req_op = 4'b0000; req_d = dpat;
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            step();
            n_vec++;
            if (gnt !== exp_g || dff_en !== 1'b1 || dff_d !== dpat[k % 4] || ack !== 4'b0000) begin
                n_bad++;
                $display("FAIL rr_issue%0d: gnt=%b en=%b d=%b ack=%b, required %b 1 %b 0000", k, gnt, dff_en, dff_d, ack, exp_g, dpat[k % 4]);
            end
            step();
            n_vec++;
            if (ack !== exp_g || rdata !== dpat[k % 4]) begin
                n_bad++;
                $display("FAIL rr_ack%0d: ack=%b rdata=%b, required %b %b", k, ack, rdata, exp_g, dpat[k % 4]);
            end
            if (k == 7) req = '0;
        end
        step();
        n_vec++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_end: gnt=%b ack=%b err=%b, required 0000 0000 0", gnt, ack, err);
        end
    endtask

    task automatic test_mismatch();
        int acks;
        bit done;
        stuck0 = 1'b1;
        req = 4'b0001; req_op = 4'b0000; req_d = 4'b0001;
        step();
        step();
        n_vec++;
        if (ack !== 4'b0001 || rdata !== 1'b0) begin
            n_bad++;
            $display("FAIL mm_ack: ack=%b rdata=%b, required 0001 0", ack, rdata);
        end
        req = '0;
        step();
        n_vec++;
        if (err !== 1'b1 || err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL mm_first: err=%b cnt=%0d, required 1 1", err, err_cnt);
        end
        req = 4'b0011; req_d = 4'b0011;
        acks = 0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            step();
            if (ack != '0) acks++;
            if (acks == 299) begin
                req = '0;
                done = 1'b1;
            end
        end
        n_vec++;
        if (!done) begin
            n_bad++;
            $display("FAIL mm_timeout: acks=%0d, required 299", acks);
        end
        step();
        n_vec++;
        if (err !== 1'b1 || err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL mm_sat: err=%b cnt=%0d, required 1 255", err, err_cnt);
        end
        stuck0 = 1'b0;
        req = 4'b0001; req_d = 4'b0001;
        step();
        step();
        req = '0;
        n_vec++;
        if (ack !== 4'b0001 || rdata !== 1'b1) begin
            n_bad++;
            $display("FAIL mm_good_ack: ack=%b rdata=%b, required 0001 1", ack, rdata);
        end
        step();
        n_vec++;
        if (err !== 1'b1 || err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL mm_sticky: err=%b cnt=%0d, required 1 255", err, err_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        req = 4'b0100; req_op = 4'b0000; req_d = 4'b0100;
        step();
        n_vec++;
        if (gnt !== 4'b0100 || dff_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: gnt=%b en=%b, required 0100 1", gnt, dff_en);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({gnt, ack, rdata, dff_en, dff_d, dff_reset, err} !== '0 || err_cnt !== '0 || fsm_state !== IDLE) begin
            n_bad++;
            $display("FAIL rst_async: gnt=%b ack=%b rdata=%b en=%b d=%b rst=%b err=%b cnt=%0d st=%0d, required all 0",
                     gnt, ack, rdata, dff_en, dff_d, dff_reset, err, err_cnt, fsm_state);
        end
        step();
        n_vec++;
        if (ack !== 4'b0000 || gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_noack: ack=%b gnt=%b, required 0000 0000", ack, gnt);
        end
        reset_n = 1'b1;
        req = 4'b1001; req_d = 4'b0001;
        step();
        n_vec++;
        if (gnt !== 4'b0001 || dff_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ptr: gnt=%b en=%b, required 0001 1", gnt, dff_en);
        end
        req = '0;
        step();
        n_vec++;
        if (ack !== 4'b0001 || rdata !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ack: ack=%b rdata=%b, required 0001 1", ack, rdata);
        end
        step();
    endtask

    task automatic test_drop_req();
        req = 4'b1000; req_op = 4'b0000; req_d = 4'b1000;
        step();
        n_vec++;
        if (gnt !== 4'b1000 || dff_en !== 1'b1 || dff_d !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_c1: gnt=%b en=%b d=%b, required 1000 1 1", gnt, dff_en, dff_d);
        end
        req = '0;
        step();
        n_vec++;
        if (ack !== 4'b1000 || rdata !== 1'b1 || gnt !== 4'b1000) begin
            n_bad++;
            $display("FAIL drop_c2: ack=%b rdata=%b gnt=%b, required 1000 1 1000", ack, rdata, gnt);
        end
        step();
        n_vec++;
        if (ack !== 4'b0000 || gnt !== 4'b0000 || fsm_state !== IDLE) begin
            n_bad++;
            $display("FAIL drop_c3: ack=%b gnt=%b st=%0d, required 0000 0000 IDLE", ack, gnt, fsm_state);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_clear();
        test_fairness();
        test_mismatch();
        test_reset_mid_op();
        test_drop_req();
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dff_access_arbiter.md
DFF_ACCESS_ARBITER -- requirements
Module: dff_access_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ERR_W, default 8, width of mismatch counter.
REQ-003 SHALL have port clk  in  1  sole clock, all state on posedge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  in  N_REQ  per-requester access request, level.
REQ-006 SHALL have port req_op  in  N_REQ  per-requester op: 0=write, 1=clear.
REQ-007 SHALL have port req_d  in  N_REQ  per-requester write data bit.
REQ-008 SHALL have port gnt  out  N_REQ  one-hot grant, zero when idle.
REQ-009 SHALL have port ack  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port rdata  out  1  flop value read back at completion, valid with ack.
REQ-011 SHALL have port dff_en  out  1  enable to the shared enable-flop.
REQ-012 SHALL have port dff_d  out  1  data to the shared enable-flop.
REQ-013 SHALL have port dff_reset  out  1  synchronous clear to the shared enable-flop.
REQ-014 SHALL have port dff_q  in  1  shared enable-flop output.
REQ-015 SHALL have port err  out  1  sticky mismatch flag.
REQ-016 SHALL have port err_cnt  out  ERR_W  saturating mismatch count.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CHECK.
REQ-018 IDLE: any req -> register one-hot gnt from round-robin pick, go ISSUE; else stay, gnt=0.
REQ-019 ISSUE (exactly one cycle): write -> dff_en=1, dff_d=req_d[g]; clear -> dff_reset=1, dff_en=0, dff_d=0; latch expected value (req_d[g] or 0); go CHECK.
REQ-020 CHECK: sample dff_q, rdata=dff_q, ack[g]=1 for this cycle only; dff_en=dff_reset=0.
REQ-021 CHECK: if dff_q != expected, set err and increment err_cnt, saturating at all-ones.
REQ-022 CHECK exit: another req pending (excluding just-served index per priority) -> new gnt, go ISSUE directly; else gnt=0, go IDLE.
REQ-023 Latency: req first seen in IDLE at cycle 0 -> gnt+dff_en cycle 1 -> ack cycle 2; back-to-back throughput one op per 2 cycles.
REQ-024 Round-robin: priority starts at index gnt+1 (mod N_REQ) after each grant; pointer 0 after reset.
REQ-025 req_op/req_d sampled only in the ISSUE cycle; gnt held stable ISSUE through CHECK.
REQ-026 req deasserted while granted: transaction still completes and ack still pulses.
REQ-027 dff_en and dff_reset SHALL never be high in the same cycle; both 0 outside ISSUE.
REQ-028 ack SHALL be one-hot or zero and equal gnt masked by CHECK.
REQ-029 err clears only on reset; err_cnt holds at max on further mismatches.

Reset
REQ-030 reset_n low asynchronously forces: state IDLE, gnt=0, ack=0, rdata=0, dff_en=0, dff_d=0, dff_reset=0, err=0, err_cnt=0, rr pointer=0.
REQ-031 Reset mid-ISSUE or mid-CHECK abandons the op with no ack; first grant after release follows REQ-023 from IDLE.

Structure
REQ-032 Package dff_ctrl_pkg SHALL hold the state enum, op encoding constants (OP_WRITE=0, OP_CLEAR=1), default N_REQ.
REQ-033 Sub-module rr_arbiter SHALL implement the combinational round-robin pick (req vector, pointer -> one-hot grant).
REQ-034 Top SHALL contain FSM, expected-value register, error logic; target 120-400 lines RTL total.

Verification
REQ-035 Single write: req[1]=1, op=0, d=1 from IDLE -> gnt=0010 cycle 1, dff_en=1 dff_d=1 cycle 1, ack=0010 rdata=1 cycle 2, err=0.
REQ-036 Clear: after REQ-035, req[2]=1 op=1 -> dff_reset=1 one cycle, ack[2] with rdata=0.
REQ-037 Fairness: req=1111 held 8 ops -> grant order 0,1,2,3,0,1,2,3, acks every 2 cycles.
REQ-038 Mismatch: flop model forces dff_q=0 on write d=1 -> err=1, err_cnt=1; 300 forced mismatches -> err_cnt=255.
REQ-039 Reset mid-op: reset_n low during ISSUE -> all outputs 0 immediately, no ack; rr pointer back to 0.
REQ-040 Drop req: req[3] drops in ISSUE cycle -> ack[3] still pulses next cycle; bench also checks dff_en/dff_reset mutual exclusion throughout.
